risc_sequencer: RTL and testbench

//  Instruction-phase controller for the 8-bit VeriRISC CPU (instance inside cpu, beside the

---
 rtl/risc_sequencer.sv | 126 ++++++++++++
 tb/tb_risc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer.sv
// Phase sequencer for the 8-bit VeriRISC CPU: steps eight phases per instruction and
// decodes phase plus IR opcode into datapath strobes, with an optional halt-and-freeze mode.
module risc_sequencer #(
  parameter int CNT_W      = 16,
  parameter bit HLT_FREEZE = 1'b1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e           phase_q, phase_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  // A frozen HLT parks in OP_ADDR without retiring; otherwise every 7->0 wrap retires one.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (!halted_q) begin
      if (HLT_FREEZE && phase_q == OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
        if (phase_q == STORE) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: directed phase-by-phase literals plus randomized opcode/zero/reset
// traffic checked every cycle against a phase-counting reference model.
module tb_risc_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [2:0]  opcode;
  logic        zero;
  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0]  phase;
  logic [15:0] instr_cnt;

  risc_sequencer #(.CNT_W(16), .HLT_FREEZE(1'b1)) dut (
    .clock(clock), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  // Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}
  logic [8:0] dut_str;
  assign dut_str = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model state: instruction position, halted flag, retired count.
  int          m_phase  = 0;
  bit          m_halted = 1'b0;
  logic [15:0] m_cnt    = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_strobes(input int ph, input bit hlt,
                                                input logic [2:0] op, input logic z);
    bit fetch, uses_mem, is_sto, is_jmp;
    if (hlt) return 9'b000000001;
    fetch    = (ph < 4);
    uses_mem = (op >= 3'd2) && (op <= 3'd5);
    is_sto   = (op == 3'd6);
    is_jmp   = (op == 3'd7);
    return {fetch,
            (ph >= 1 && ph <= 3) || (ph >= 5 && uses_mem),
            (ph == 2 || ph == 3),
            (ph == 4) || (ph == 6 && op == 3'd1 && z),
            is_jmp && ph >= 6,
            uses_mem && ph == 7,
            is_sto && ph >= 6,
            is_sto && ph == 7,
            (ph == 4) && (op == 3'd0)};
  endfunction

  always @(posedge clock) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_halted = 1'b0;
      m_cnt    = '0;
    end else if (!m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) begin
        m_halted = 1'b1;
      end else if (m_phase == 7) begin
        m_phase = 0;
        m_cnt   = m_cnt + 16'd1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("model_strobes", 32'(dut_str), 32'(model_strobes(m_phase, m_halted, opcode, zero)));
      chk("model_phase", 32'(phase), 32'(m_phase));
      chk("model_cnt", 32'(instr_cnt), 32'(m_cnt));
      if (rd && data_e) chk("rd_data_e_overlap", 32'(1), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starting at phase 0, run one instruction and check the strobes at phase ph.
  task automatic lit_at(input string nm, input logic [2:0] op, input logic z,
                        input int ph, input logic [8:0] exp);
    opcode = op;
    zero   = z;
    repeat (ph) tick();
    @(negedge clock);
    chk(nm, 32'(dut_str), 32'(exp));
    repeat (8 - ph) tick();
  endtask

  logic [8:0] t1_exp [8];

  initial begin
    int hc;
    t1_exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
               9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    rst_n  = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    tick();
    rst_n    = 1'b1;
    check_en = 1'b1;

    // ADD through one full instruction
    for (int p = 0; p < 8; p++) begin
      @(negedge clock);
      chk("t1_strobes", 32'(dut_str), 32'(t1_exp[p]));
      chk("t1_phase", 32'(phase), p);
      if (p == 0) chk("t1_cnt_start", 32'(instr_cnt), 32'(0));
      tick();
    end
    @(negedge clock);
    chk("t1_cnt_wrap", 32'(instr_cnt), 32'(1));
    chk("t1_phase_wrap", 32'(phase), 32'(0));

    lit_at("skz_z1_ph6", 3'd1, 1'b1, 6, 9'b000100000);
    lit_at("skz_z0_ph6", 3'd1, 1'b0, 6, 9'b000000000);
    lit_at("skz_ph5",    3'd1, 1'b1, 5, 9'b000000000);
    lit_at("sto_ph6",    3'd6, 1'b0, 6, 9'b000000100);
    lit_at("sto_ph7",    3'd6, 1'b0, 7, 9'b000000110);
    lit_at("jmp_ph6",    3'd7, 1'b0, 6, 9'b000010000);
    lit_at("jmp_ph7",    3'd7, 1'b0, 7, 9'b000010000);
    @(negedge clock);
    chk("cnt_after_directed", 32'(instr_cnt), 32'(8));

    // HLT freezes in phase 4
    opcode = 3'd0;
    repeat (4) tick();
    @(negedge clock);
    chk("hlt_ph4", 32'(dut_str), 32'(9'b000100001));
    repeat (20) begin
      tick();
      @(negedge clock);
      chk("halted_strobes", 32'(dut_str), 32'(9'b000000001));
    end
    chk("halted_phase", 32'(phase), 32'(4));
    chk("halted_cnt", 32'(instr_cnt), 32'(8));

    // Reset while halted
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst_halt_strobes", 32'(dut_str), 32'(9'b100000000));
    chk("rst_halt_phase", 32'(phase), 32'(0));
    chk("rst_halt_cnt", 32'(instr_cnt), 32'(0));

    // Reset mid-instruction (LDA phase 5)
    opcode = 3'd5;
    repeat (5) tick();
    @(negedge clock);
    chk("lda_ph5", 32'(dut_str), 32'(9'b010000000));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst_lda_strobes", 32'(dut_str), 32'(9'b100000000));
    chk("rst_lda_phase", 32'(phase), 32'(0));
    repeat (8) tick();
    @(negedge clock);
    chk("resume_cnt", 32'(instr_cnt), 32'(1));

    // Randomized traffic against the model
    hc = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) opcode = 3'($urandom_range(0, 7));
      zero  = 1'($urandom_range(0, 1));
      hc    = m_halted ? hc + 1 : 0;
      rst_n = !(($urandom_range(0, 79) == 0) || (hc > 6));
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
